// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - RiSC-16 opcodes, FSM states, ALU ops and field positions
package risc16_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  localparam int OPC_LSB = 13;
  localparam int RA_LSB  = 10;
  localparam int RB_LSB  = 7;
  localparam int RC_LSB  = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_NAND,
    ALU_PASS,
    ALU_EQ
  } alu_op_e;

  function automatic logic [15:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/risc16_alu.sv
// rtl/risc16_alu.sv - combinational ADD/NAND/PASS datapath with equality flag
module risc16_alu
  import risc16_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  alu_op_e     op_i,
  output logic [15:0] y_o,
  output logic        eq_o
);

  always_comb begin
    y_o = 16'h0000;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_NAND: y_o = ~(a_i & b_i);
      ALU_PASS: y_o = b_i;
      default:  y_o = 16'h0000;
    endcase
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/risc16_multicycle_core.sv
// rtl/risc16_multicycle_core.sv - multi-cycle RiSC-16 core with req/ack memory ports
// RISC16_TRACE_EN adds retire_valid_o/retire_pc_o/retire_insn_o.
module risc16_multicycle_core
  import risc16_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [15:0]     imem_rdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [15:0]     dmem_addr_o,
  output logic [15:0]     dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [15:0]     dmem_rdata_i,
  output logic            halted_o,
  output logic            error_o
`ifdef RISC16_TRACE_EN
  ,
  output logic            retire_valid_o,
  output logic [PC_W-1:0] retire_pc_o,
  output logic [15:0]     retire_insn_o
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d, pc_plus1;
  logic [15:0]     ir_q, ir_d, ra_q, ra_d, rb_q, rb_d, rc_q, rc_d, res_q, res_d;
  logic            taken_q, taken_d;
  logic [15:0]     wait_q, wait_d;
  logic            imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic [15:0]     rf_q [8];
  logic            rf_we;

  logic [2:0]  opc, ra_idx, rb_idx, rc_idx;
  logic [6:0]  imm7;
  logic [9:0]  imm10;
  logic        is_mem, is_halt, writes_rf;
  logic        iack, dack, req_active, timeout;
  logic [15:0] alu_a, alu_b, alu_y;
  alu_op_e     alu_op;
  logic        alu_eq;

  assign opc    = ir_q[OPC_LSB +: 3];
  assign ra_idx = ir_q[RA_LSB +: 3];
  assign rb_idx = ir_q[RB_LSB +: 3];
  assign rc_idx = ir_q[RC_LSB +: 3];
  assign imm7   = ir_q[6:0];
  assign imm10  = ir_q[9:0];

  assign is_mem    = (opc == OP_LW) || (opc == OP_SW);
  assign is_halt   = (opc == OP_JALR) && (imm7 != 7'd0);
  assign writes_rf = (opc != OP_SW) && (opc != OP_BEQ);
  assign pc_plus1  = pc_q + PC_W'(1);

  // Acks only count while the matching request is actually up.
  assign iack       = imem_req_q & imem_ack_i;
  assign dack       = dmem_req_q & dmem_ack_i;
  assign req_active = imem_req_q | dmem_req_q;
  assign timeout    = (MAX_WAIT != 0) && req_active && !iack && !dack &&
                      (wait_q == 16'(MAX_WAIT - 1));

  always_comb begin
    alu_a  = rb_q;
    alu_b  = rc_q;
    alu_op = ALU_ADD;
    case (opc)
      OP_ADDI, OP_LW, OP_SW: alu_b = sext7(imm7);
      OP_NAND: alu_op = ALU_NAND;
      OP_LUI: begin
        alu_b  = {imm10, 6'b000000};
        alu_op = ALU_PASS;
      end
      OP_BEQ: begin
        alu_a  = ra_q;
        alu_b  = rb_q;
        alu_op = ALU_EQ;
      end
      OP_JALR: begin
        alu_b  = 16'(pc_plus1);
        alu_op = ALU_PASS;
      end
      default: ;
    endcase
  end

  risc16_alu u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .y_o  (alu_y),
    .eq_o (alu_eq)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    res_d   = res_q;
    tgt_d   = tgt_q;
    taken_d = taken_q;
    rf_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (iack) begin
          ir_d    = imem_rdata_i;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        ra_d    = rf_q[ra_idx];
        rb_d    = rf_q[rb_idx];
        rc_d    = rf_q[rc_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_y;
        taken_d = alu_eq;
        tgt_d   = PC_W'(16'(pc_q) + 16'd1 + sext7(imm7));
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dack) begin
          if (opc == OP_LW) res_d = dmem_rdata_i;
          state_d = S_WB;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else begin
          rf_we   = writes_rf && (ra_idx != 3'd0);
          state_d = S_FETCH;
          if (opc == OP_JALR)               pc_d = rb_q[PC_W-1:0];
          else if (opc == OP_BEQ && taken_q) pc_d = tgt_q;
          else                               pc_d = pc_plus1;
        end
      end
      default: ;
    endcase
    wait_d     = (state_d != state_q) ? 16'd0 : (req_active ? wait_q + 16'd1 : wait_q);
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
  end

  // Requests are registered so they read 0 while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_W'(RESET_PC);
      ir_q       <= 16'd0;
      ra_q       <= 16'd0;
      rb_q       <= 16'd0;
      rc_q       <= 16'd0;
      res_q      <= 16'd0;
      tgt_q      <= '0;
      taken_q    <= 1'b0;
      wait_q     <= 16'd0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rc_q       <= rc_d;
      res_q      <= res_d;
      tgt_q      <= tgt_d;
      taken_q    <= taken_d;
      wait_q     <= wait_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      if (rf_we) rf_q[ra_idx] <= res_q;
    end
  end

  assign imem_req_o   = imem_req_q;
  assign imem_addr_o  = imem_req_q ? pc_q : '0;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_req_q && (opc == OP_SW);
  assign dmem_addr_o  = dmem_req_q ? res_q : 16'd0;
  assign dmem_wdata_o = (dmem_req_q && (opc == OP_SW)) ? ra_q : 16'd0;
  assign halted_o     = (state_q == S_HALT);
  assign error_o      = (state_q == S_ERROR);

`ifdef RISC16_TRACE_EN
  assign retire_valid_o = (state_q == S_WB);
  assign retire_pc_o    = pc_q;
  assign retire_insn_o  = ir_q;
`endif

endmodule

// File: tb/tb_risc16_multicycle_core.sv
// tb/tb_risc16_multicycle_core.sv - scoreboard bench for risc16_multicycle_core
module tb_risc16_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, error;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  risc16_multicycle_core #(.PC_W(16), .RESET_PC(0), .MAX_WAIT(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata),
    .halted_o     (halted),
    .error_o      (error)
  );

  localparam logic [15:0] HALT_W = 16'hE001;

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:65535];
  int          idelay, ld_delay, errors, checks, cyc, last_fetch, extra_fetch, extra_dmem;
  bit          inject, strict;
  logic [15:0] exp_pc [$];
  int          exp_lat [$];
  logic [32:0] exp_d [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [6:0] imm);
    return {op, ra, rb, imm};
  endfunction
  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [2:0] rc);
    return {op, ra, rb, 4'b0000, rc};
  endfunction

  task automatic exp_f(input logic [15:0] pc, input int lat);
    exp_pc.push_back(pc);
    exp_lat.push_back(lat);
  endtask
  task automatic exp_st(input logic [15:0] a, input logic [15:0] d);
    exp_d.push_back({1'b1, a, d});
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_W;
  endtask

  initial begin : imem_resp
    int cnt;
    logic [15:0] e;
    int l;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_ack = 1'b0;
        cnt = 0;
      end else if (inject) begin
        imem_ack = 1'b1;
        imem_rdata = HALT_W;
      end else if (imem_req) begin
        if (cnt >= idelay) begin
          imem_ack = 1'b1;
          imem_rdata = imem[imem_addr[7:0]];
          if (exp_pc.size() > 0) begin
            e = exp_pc.pop_front();
            l = exp_lat.pop_front();
            check_eq("fetch_pc", imem_addr, e);
            if (l > 0) check_eq("cycles_per_insn", cyc - last_fetch, l);
          end else if (strict) begin
            extra_fetch++;
          end
          last_fetch = cyc;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin : dmem_resp
    int cnt;
    logic [32:0] e;
    cnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dmem_ack = 1'b0;
        cnt = 0;
      end else if (dmem_req) begin
        if (cnt >= (dmem_we ? 0 : ld_delay)) begin
          dmem_ack = 1'b1;
          dmem_rdata = dmem[dmem_addr];
          if (dmem_we) dmem[dmem_addr] = dmem_wdata;
          if (exp_d.size() > 0) begin
            e = exp_d.pop_front();
            check_eq("dmem_we", dmem_we, e[32]);
            check_eq("dmem_addr", dmem_addr, e[31:16]);
            if (e[32]) check_eq("dmem_wdata", dmem_wdata, e[15:0]);
          end else begin
            extra_dmem++;
          end
        end else begin
          dmem_ack = 1'b0;
          cnt++;
        end
      end else begin
        dmem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; inject = 1'b0; strict = 1'b0;
    idelay = 0; ld_delay = 0; errors = 0; checks = 0; cyc = 0; last_fetch = 0;
    extra_fetch = 0; extra_dmem = 0;
    for (int i = 0; i < 65536; i++) dmem[i] = 16'h0;
    clear_imem();
    imem[8'h00] = rri(3'd1, 3'd1, 3'd0, 7'h7F);   // ADDI R1,R0,-1
    imem[8'h01] = rrr(3'd0, 3'd2, 3'd1, 3'd1);    // ADD R2,R1,R1
    imem[8'h02] = rri(3'd1, 3'd6, 3'd0, 7'h20);   // ADDI R6,R0,0x20
    imem[8'h03] = rri(3'd7, 3'd5, 3'd6, 7'h00);   // JALR R5,R6
    imem[8'h20] = rri(3'd4, 3'd1, 3'd0, 7'h01);   // SW R1,R0,1
    imem[8'h21] = rri(3'd4, 3'd2, 3'd0, 7'h02);   // SW R2,R0,2
    imem[8'h22] = rri(3'd4, 3'd5, 3'd0, 7'h03);   // SW R5,R0,3
    imem[8'h23] = rri(3'd1, 3'd0, 3'd0, 7'h07);   // ADDI R0,R0,7
    imem[8'h24] = rri(3'd4, 3'd0, 3'd0, 7'h04);   // SW R0,R0,4
    imem[8'h25] = rri(3'd1, 3'd7, 3'd0, 7'h28);   // ADDI R7,R0,0x28
    imem[8'h26] = rri(3'd7, 3'd7, 3'd7, 7'h00);   // JALR R7,R7
    imem[8'h28] = rri(3'd4, 3'd7, 3'd0, 7'h7E);   // SW R7,R0,-2
    imem[8'h29] = rrr(3'd2, 3'd3, 3'd1, 3'd2);    // NAND R3,R1,R2
    imem[8'h2A] = rri(3'd4, 3'd3, 3'd7, 7'h01);   // SW R3,R7,1
    imem[8'h2B] = rri(3'd6, 3'd1, 3'd2, 7'h05);   // BEQ R1,R2,5 (not taken)
    imem[8'h2C] = rri(3'd6, 3'd1, 3'd1, 7'h02);   // BEQ R1,R1,2 (taken)
    imem[8'h2F] = HALT_W;

    repeat (3) @(negedge clk);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, 0);
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_dmem_we", dmem_we, 0);
    check_eq("rst_dmem_addr", dmem_addr, 0);
    check_eq("rst_dmem_wdata", dmem_wdata, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_error", error, 0);

    // Abandon a stalled fetch with reset, then offer a stray ack while req is low.
    idelay = 3;
    @(posedge clk); #2 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req) begin n = 1; break; end
    end
    check_eq("fetch_req_seen", n, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_fetch_req", imem_req, 0);
    check_eq("rst_mid_fetch_addr", imem_addr, 0);
    inject = 1'b1; idelay = 0; strict = 1'b1;
    exp_f(16'h00, 0); exp_f(16'h01, 4); exp_f(16'h02, 4); exp_f(16'h03, 4);
    exp_f(16'h20, 4); exp_f(16'h21, 5); exp_f(16'h22, 5); exp_f(16'h23, 5);
    exp_f(16'h24, 4); exp_f(16'h25, 5); exp_f(16'h26, 4); exp_f(16'h28, 4);
    exp_f(16'h29, 5); exp_f(16'h2A, 4); exp_f(16'h2B, 5); exp_f(16'h2C, 4);
    exp_f(16'h2F, 4);
    exp_st(16'h0001, 16'hFFFF); exp_st(16'h0002, 16'hFFFE); exp_st(16'h0003, 16'h0004);
    exp_st(16'h0004, 16'h0000); exp_st(16'hFFFE, 16'h0027); exp_st(16'h0028, 16'h0001);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (halted) break;
    end
    check_eq("halted", halted, 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req) n++;
    end
    check_eq("req_after_halt", n, 0);
    check_eq("halted_held", halted, 1);
    check_eq("a_fetches_left", exp_pc.size(), 0);
    check_eq("a_dmem_left", exp_d.size(), 0);
    check_eq("a_extra_fetch", extra_fetch, 0);
    check_eq("a_extra_dmem", extra_dmem, 0);

    // LUI/SW/LW with a stalled load, then a BEQ self-loop.
    @(posedge clk); #2 rst_n = 1'b0;
    strict = 1'b0; ld_delay = 3;
    clear_imem();
    imem[0] = {3'd3, 3'd3, 10'h3FF};              // LUI R3,0x3FF
    imem[1] = rri(3'd4, 3'd3, 3'd0, 7'h05);       // SW R3,R0,5
    imem[2] = rri(3'd5, 3'd4, 3'd0, 7'h05);       // LW R4,R0,5
    imem[3] = rri(3'd4, 3'd4, 3'd0, 7'h06);       // SW R4,R0,6
    imem[4] = rri(3'd6, 3'd0, 3'd0, 7'h7F);       // BEQ R0,R0,-1
    exp_f(16'h0, 0); exp_f(16'h1, 4); exp_f(16'h2, 5); exp_f(16'h3, 8);
    exp_f(16'h4, 5); exp_f(16'h4, 4); exp_f(16'h4, 4);
    exp_st(16'h0005, 16'hFFC0);
    exp_d.push_back({1'b0, 16'h0005, 16'h0000});
    exp_st(16'h0006, 16'hFFC0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_pc.size() == 0) break;
    end
    check_eq("b_fetches_left", exp_pc.size(), 0);
    check_eq("b_dmem_left", exp_d.size(), 0);
    check_eq("b_extra_dmem", extra_dmem, 0);
    check_eq("b_not_halted", halted, 0);

    // Instruction memory never answers: expect timeout after MAX_WAIT request cycles.
    @(posedge clk); #2 rst_n = 1'b0;
    idelay = 100000;
    @(posedge clk); #2 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (error) break;
      if (imem_req) n++;
    end
    check_eq("timeout_error", error, 1);
    check_eq("timeout_req_cycles", n, 8);
    check_eq("timeout_req_drop", imem_req, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (error && !imem_req && !dmem_req) n++;
    end
    check_eq("error_sticky", n, 20);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("error_cleared", error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
